// File: rtl/centroid_sched.sv
// Per-frame centroid scheduler: latches the threshold accumulators on frame-done and
// sequences a shared divider (x then y) and a sqrt core, publishing one coherent result set.
module centroid_sched #(
  parameter int ACC_W    = 32,
  parameter int OUT_W    = 10,
  parameter int MIN_SIZE = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 frame_done_in,
  input  logic [ACC_W-1:0]     size_in,
  input  logic [ACC_W-1:0]     sum_x_in,
  input  logic [ACC_W-1:0]     sum_y_in,
  output logic [ACC_W-1:0]     div_dividend_out,
  output logic [ACC_W-1:0]     div_divisor_out,
  output logic                 div_valid_out,
  input  logic                 div_ready_in,
  input  logic [ACC_W-1:0]     div_quot_in,
  input  logic                 div_valid_in,
  output logic [ACC_W-1:0]     sqrt_data_out,
  output logic                 sqrt_valid_out,
  input  logic                 sqrt_ready_in,
  input  logic [ACC_W/2-1:0]   sqrt_root_in,
  input  logic                 sqrt_valid_in,
  output logic [OUT_W-1:0]     x_mean_out,
  output logic [OUT_W-1:0]     y_mean_out,
  output logic [ACC_W/2-1:0]   radius_out,
  output logic                 result_valid_out,
  output logic                 target_lost_out,
  output logic                 busy_out,
  output logic [7:0]           overrun_cnt_out,
  output logic                 timeout_out
);
  localparam int RW = ACC_W / 2;

  typedef enum logic [2:0] {IDLE, ISSUE_X, ISSUE_Y, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  size_q, sumx_q, sumy_q;
  logic              xg_q, xg_d, yg_q, yg_d, rg_q, rg_d, sqiss_q, sqiss_d;
  logic [OUT_W-1:0]  xres_q, xres_d, yres_q, yres_d;
  logic [RW-1:0]     rres_q, rres_d;
  logic [31:0]       tcnt_q, tcnt_d;
  logic [OUT_W-1:0]  xout_q, yout_q;
  logic [RW-1:0]     rout_q;
  logic              lost_q, tmo_q, tmo_set, active;
  logic [7:0]        ovr_q;

  function automatic logic [OUT_W-1:0] sat(input logic [ACC_W-1:0] q);
    if (|q[ACC_W-1:OUT_W]) return '1;
    return q[OUT_W-1:0];
  endfunction

  assign active = (state_q == ISSUE_X) || (state_q == ISSUE_Y) || (state_q == WAIT);

  always_comb begin
    state_d          = state_q;
    xg_d             = xg_q;
    yg_d             = yg_q;
    rg_d             = rg_q;
    sqiss_d          = sqiss_q;
    xres_d           = xres_q;
    yres_d           = yres_q;
    rres_d           = rres_q;
    tcnt_d           = tcnt_q;
    tmo_set          = 1'b0;
    div_dividend_out = sumx_q;
    div_divisor_out  = size_q;
    div_valid_out    = 1'b0;
    sqrt_valid_out   = 1'b0;

    if (active) begin
      // sqrt request runs independently of the divider until it is accepted
      sqrt_valid_out = !sqiss_q;
      if (sqrt_valid_out && sqrt_ready_in) sqiss_d = 1'b1;
      if (div_valid_in) begin
        if (!xg_q) begin
          xg_d   = 1'b1;
          xres_d = sat(div_quot_in);
        end else if (!yg_q) begin
          yg_d   = 1'b1;
          yres_d = sat(div_quot_in);
        end
      end
      if (sqrt_valid_in && !rg_q) begin
        rg_d   = 1'b1;
        rres_d = sqrt_root_in;
      end
    end

    case (state_q)
      IDLE: begin
        if (frame_done_in && (size_in >= ACC_W'(MIN_SIZE))) begin
          state_d = ISSUE_X;
          xg_d    = 1'b0;
          yg_d    = 1'b0;
          rg_d    = 1'b0;
          sqiss_d = 1'b0;
          tcnt_d  = '0;
        end
      end
      ISSUE_X: begin
        div_valid_out = 1'b1;
        if (div_ready_in) state_d = ISSUE_Y;
      end
      ISSUE_Y: begin
        div_dividend_out = sumy_q;
        div_valid_out    = 1'b1;
        if (div_ready_in) state_d = WAIT;
      end
      WAIT: begin
        // results landing this cycle count, so DONE follows the last one directly
        if (xg_d && yg_d && rg_d) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      tcnt_d = tcnt_q + 32'd1;
      if (state_q != DONE && tcnt_q == 32'(TIMEOUT - 1)) begin
        state_d = IDLE;
        tmo_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      size_q  <= '0;
      sumx_q  <= '0;
      sumy_q  <= '0;
      xg_q    <= 1'b0;
      yg_q    <= 1'b0;
      rg_q    <= 1'b0;
      sqiss_q <= 1'b0;
      xres_q  <= '0;
      yres_q  <= '0;
      rres_q  <= '0;
      tcnt_q  <= '0;
      xout_q  <= '0;
      yout_q  <= '0;
      rout_q  <= '0;
      lost_q  <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      xg_q    <= xg_d;
      yg_q    <= yg_d;
      rg_q    <= rg_d;
      sqiss_q <= sqiss_d;
      xres_q  <= xres_d;
      yres_q  <= yres_d;
      rres_q  <= rres_d;
      tcnt_q  <= tcnt_d;
      if (state_q == IDLE && frame_done_in) begin
        size_q <= size_in;
        sumx_q <= sum_x_in;
        sumy_q <= sum_y_in;
        if (size_in < ACC_W'(MIN_SIZE)) lost_q <= 1'b1;
      end
      // outputs load on entry to DONE so they change together with the valid pulse
      if (state_d == DONE && state_q != DONE) begin
        xout_q <= xres_d;
        yout_q <= yres_d;
        rout_q <= rres_d;
        lost_q <= 1'b0;
      end
      if (tmo_set) tmo_q <= 1'b1;
      if (frame_done_in && state_q != IDLE && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
    end
  end

  assign sqrt_data_out    = size_q;
  assign x_mean_out       = xout_q;
  assign y_mean_out       = yout_q;
  assign radius_out       = rout_q;
  assign result_valid_out = (state_q == DONE);
  assign target_lost_out  = lost_q;
  assign busy_out         = (state_q != IDLE);
  assign overrun_cnt_out  = ovr_q;
  assign timeout_out      = tmo_q;
endmodule
